adma_dm_rd_splitter: RTL
========================

Name: adma_dm_rd_splitter

Overview:
- Next-generation read host for the DMA data mover, AXI4 source only.
- Accepts one whole per-channel read transfer (start address, total beat count) and splits it into legal AXI4 INCR bursts:
  - no burst exceeds MAX_BURST_BEATS;
  - no burst crosses a BOUNDARY_B-byte boundary.
- Issues the bursts on AR with a bounded number outstanding.
- Returns R data tagged with channel and end-of-transfer, plus per-channel done and error pulses.
- Sits between the channel arbiter and the AXI4 master port.

Parameters:
- DMA_CHN_NUM, 4, number of DMA channels.
- DMA_CHN_NUM_W, clog2(DMA_CHN_NUM) (min 1), derived; do not set.
- SRC_ADDR_W, 32, source address width.
- ATX_SRC_DATA_W, 256, R data width; bytes per beat BPB = ATX_SRC_DATA_W/8, a power of 2.
- MST_ID_W, 5, AXI ID width; must be >= DMA_CHN_NUM_W.
- ATX_LEN_W, 8, AxLEN width.
- XFER_BEAT_W, 16, width of the transfer beat count.
- MAX_BURST_BEATS, 16, burst length cap; at most 2^ATX_LEN_W.
- BOUNDARY_B, 4096, byte boundary no burst may cross; a power of 2 and >= BPB.
- ATX_NUM_OSTD, 4, maximum outstanding AR bursts.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- xfer_chn_id  in  DMA_CHN_NUM_W  requesting channel.
- xfer_addr  in  SRC_ADDR_W  start address; low log2(BPB) bits are ignored (treated as 0).
- xfer_beats  in  XFER_BEAT_W  total beats; 0 is illegal and dropped.
- xfer_vld  in  1  transfer request valid.
- xfer_rdy  out  1  splitter ready to accept a transfer.
- m_arid_o  out  MST_ID_W  channel id, zero-extended.
- m_araddr_o  out  SRC_ADDR_W  burst address.
- m_arlen_o  out  ATX_LEN_W  burst length minus 1.
- m_arburst_o  out  2  constant 2'b01 (INCR).
- m_arvalid_o  out  1  AR valid.
- m_arready_i  in  1  AR ready.
- m_rid_i  in  MST_ID_W  R id.
- m_rdata_i  in  ATX_SRC_DATA_W  R data.
- m_rresp_i  in  2  R response.
- m_rlast_i  in  1  R last beat of burst.
- m_rvalid_i  in  1  R valid.
- m_rready_o  out  1  R ready.
- atx_rdata  out  ATX_SRC_DATA_W  data out.
- atx_rdata_chn  out  DMA_CHN_NUM_W  channel of the data beat (m_rid_i[DMA_CHN_NUM_W-1:0]).
- atx_rdata_last  out  1  final beat of the whole transfer.
- atx_rdata_vld  out  1  data valid.
- atx_rdata_rdy  in  1  data ready.
- xfer_done  out  DMA_CHN_NUM  one-cycle pulse per channel when its transfer completes.
- xfer_err  out  DMA_CHN_NUM  sticky error flag per channel.
- perf_ar_cnt  out  32  AR handshakes counted (see Optional Feature).
- perf_beat_cnt  out  32  R beats counted (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge) forces these outputs to 0: xfer_rdy, m_arvalid_o, xfer_done, xfer_err, both perf counters.
- Reset also clears all state and counters. Reset mid-transfer abandons the transfer; in-flight R beats are not tracked after reset.
- FSM states: IDLE, CALC, ISSUE.
  - IDLE: xfer_rdy=1. On xfer_vld, latch channel, aligned address and beats, then go to CALC. Accepts only if xfer_beats != 0.
  - CALC (1 cycle): compute
    - bnd = (BOUNDARY_B - (addr mod BOUNDARY_B)) / BPB;
    - len = min(remaining, MAX_BURST_BEATS, bnd).
    - Go to ISSUE.
  - ISSUE: m_arvalid_o=1 only while ostd_cnt < ATX_NUM_OSTD.
  - The AR payload is held stable while arvalid=1 and arready=0.
  - On AR handshake: addr += len*BPB; remaining -= len; ostd_cnt++. Then go to CALC if remaining != 0, else IDLE.
- One transfer is split at a time. A second transfer waits in xfer_rdy=0 until the current one is fully issued; its data may overlap the previous transfer's R beats.
- Per-channel beat counter pend[c], XFER_BEAT_W+1 bits wide:
  - loaded with xfer_beats on accept;
  - decremented on each R beat of channel c.
  - atx_rdata_last = (pend[c]==1).
  - On the last beat, xfer_done[c] pulses on the next cycle.
- ostd_cnt is decremented on an R handshake with m_rlast_i=1. A simultaneous AR handshake and R-last leaves ostd_cnt unchanged.
- R path is combinational pass-through with zero latency:
  - m_rready_o = atx_rdata_rdy;
  - atx_rdata_vld = m_rvalid_i.
- Error handling:
  - m_rresp_i[1]=1 on any beat sets xfer_err[c].
  - xfer_err[c] clears when a new transfer for c is accepted.
  - Data is still forwarded.
- Beat from a channel with pend=0 (protocol violation): forward the beat, set xfer_err[c], do not decrement pend[c].

Optional Feature:
- Macro: ADMA_RD_SPLITTER_PERF_EN.
- Defined: perf_ar_cnt counts AR handshakes and perf_beat_cnt counts R handshakes. Both are 32-bit, wrap at 2^32 and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Decomposition:
- Package adma_dm_pkg holds:
  - AXI burst encodings (INCR=2'b01);
  - RRESP bit definitions (SLVERR/DECERR check bit 1);
  - the splitter FSM state enum.
- One natural sub-module: adma_dm_burst_calc. Purely combinational: addr, remaining → len, next_addr, next_remaining.

Test Plan:
- BPB=32, addr=0x0000, beats=40 → bursts (len-1) 15,15,7 at 0x000, 0x200, 0x400. atx_rdata_last on beat 40; xfer_done[chn] pulses once.
- addr=0x0FC0, beats=4 → bursts of 2 beats at 0x0FC0 and 2 beats at 0x1000, so no 4KB crossing.
- ATX_NUM_OSTD=4, arready=1, R withheld, beats=96 → exactly 4 ARs issued, then arvalid=0 until an rlast returns, then the 5th AR issues.
- Two channels interleave R beats (ch1 beat, ch2 beat, alternating) → atx_rdata_chn follows rid and each channel's last/done fires independently.
- rresp=2'b10 on beat 3 of ch0 → xfer_err[0]=1 and stays 1; cleared on the next ch0 accept.
- rst asserted mid-ISSUE with arvalid=1 and arready=0 → next cycle arvalid=0, xfer_rdy=0, FSM in IDLE. The cycle after rst deasserts, xfer_rdy=1.

Source files
------------

// File: rtl/adma_dm_pkg.sv
// Shared definitions for the DMA data-mover read path: AXI encodings and the splitter FSM state.
package adma_dm_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  // SLVERR (2'b10) and DECERR (2'b11) both have bit 1 set
  localparam int RRESP_ERR_BIT = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE
  } splt_state_e;
endpackage

// File: rtl/adma_dm_burst_calc.sv
// Combinational burst sizing: the longest INCR burst from addr that respects the beat cap and
// the byte boundary, plus the address and beat count left once it has been issued.
module adma_dm_burst_calc
  import adma_dm_pkg::*;
#(
  parameter int SRC_ADDR_W      = 32,
  parameter int XFER_BEAT_W     = 16,
  parameter int BPB             = 32,
  parameter int MAX_BURST_BEATS = 16,
  parameter int BOUNDARY_B      = 4096,
  parameter int LEN_W           = 9
)(
  input  logic [SRC_ADDR_W-1:0]  addr,
  input  logic [XFER_BEAT_W-1:0] remaining,
  output logic [LEN_W-1:0]       len,
  output logic [SRC_ADDR_W-1:0]  next_addr,
  output logic [XFER_BEAT_W-1:0] next_remaining
);
  localparam int BPB_W = $clog2(BPB);
  localparam int BND_W = $clog2(BOUNDARY_B);
  localparam int CW    = ((XFER_BEAT_W > BND_W) ? XFER_BEAT_W : BND_W) + 1;

  logic [CW-1:0] off_beats, bnd, l;

  always_comb begin
    off_beats = CW'(addr[BND_W-1:0] >> BPB_W);
    bnd       = CW'(BOUNDARY_B / BPB) - off_beats;
    l         = CW'(remaining);
    if (CW'(MAX_BURST_BEATS) < l) l = CW'(MAX_BURST_BEATS);
    if (bnd < l) l = bnd;
    len            = LEN_W'(l);
    next_addr      = addr + (SRC_ADDR_W'(l) << BPB_W);
    next_remaining = remaining - XFER_BEAT_W'(l);
  end
endmodule

// File: rtl/adma_dm_rd_splitter.sv
// AXI4 read host: splits one DMA transfer at a time into legal INCR bursts on AR and forwards R
// data with channel/end-of-transfer tags. Define ADMA_RD_SPLITTER_PERF_EN for AR/beat counters.
module adma_dm_rd_splitter
  import adma_dm_pkg::*;
#(
  parameter int DMA_CHN_NUM     = 4,
  parameter int DMA_CHN_NUM_W   = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
  parameter int SRC_ADDR_W      = 32,
  parameter int ATX_SRC_DATA_W  = 256,
  parameter int MST_ID_W        = 5,
  parameter int ATX_LEN_W       = 8,
  parameter int XFER_BEAT_W     = 16,
  parameter int MAX_BURST_BEATS = 16,
  parameter int BOUNDARY_B      = 4096,
  parameter int ATX_NUM_OSTD    = 4
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DMA_CHN_NUM_W-1:0]  xfer_chn_id,
  input  logic [SRC_ADDR_W-1:0]     xfer_addr,
  input  logic [XFER_BEAT_W-1:0]    xfer_beats,
  input  logic                      xfer_vld,
  output logic                      xfer_rdy,
  output logic [MST_ID_W-1:0]       m_arid_o,
  output logic [SRC_ADDR_W-1:0]     m_araddr_o,
  output logic [ATX_LEN_W-1:0]      m_arlen_o,
  output logic [1:0]                m_arburst_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  input  logic [MST_ID_W-1:0]       m_rid_i,
  input  logic [ATX_SRC_DATA_W-1:0] m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rlast_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o,
  output logic [ATX_SRC_DATA_W-1:0] atx_rdata,
  output logic [DMA_CHN_NUM_W-1:0]  atx_rdata_chn,
  output logic                      atx_rdata_last,
  output logic                      atx_rdata_vld,
  input  logic                      atx_rdata_rdy,
  output logic [DMA_CHN_NUM-1:0]    xfer_done,
  output logic [DMA_CHN_NUM-1:0]    xfer_err,
  output logic [31:0]               perf_ar_cnt,
  output logic [31:0]               perf_beat_cnt
);
  localparam int BPB    = ATX_SRC_DATA_W / 8;
  localparam int LEN_W  = ATX_LEN_W + 1;
  localparam int OSTD_W = $clog2(ATX_NUM_OSTD + 1);

  splt_state_e                           state;
  logic [DMA_CHN_NUM_W-1:0]              chn_q;
  logic [SRC_ADDR_W-1:0]                 addr_q, next_addr;
  logic [XFER_BEAT_W-1:0]                rem_q, next_rem;
  logic [ATX_LEN_W-1:0]                  arlen_q;
  logic [LEN_W-1:0]                      calc_len;
  logic [OSTD_W-1:0]                     ostd_cnt, ostd_nxt;
  logic [DMA_CHN_NUM-1:0][XFER_BEAT_W:0] pend;
  logic [DMA_CHN_NUM_W-1:0]              r_chn;
  logic accept, ar_hs, r_hs, r_dec, ostd_lt, r_pend_zero, r_pend_one;
  logic unused_in;

  adma_dm_burst_calc #(
    .SRC_ADDR_W(SRC_ADDR_W), .XFER_BEAT_W(XFER_BEAT_W), .BPB(BPB),
    .MAX_BURST_BEATS(MAX_BURST_BEATS), .BOUNDARY_B(BOUNDARY_B), .LEN_W(LEN_W)
  ) u_calc (
    .addr(addr_q), .remaining(rem_q), .len(calc_len),
    .next_addr(next_addr), .next_remaining(next_rem)
  );

  assign unused_in   = ^{m_rid_i, m_rresp_i[0]};
  assign accept      = (state == S_IDLE) && xfer_rdy && xfer_vld && (xfer_beats != '0);
  assign ar_hs       = m_arvalid_o && m_arready_i;
  assign r_hs        = m_rvalid_i && atx_rdata_rdy;
  assign r_chn       = m_rid_i[DMA_CHN_NUM_W-1:0];
  assign r_dec       = r_hs && m_rlast_i && (ostd_cnt != '0);
  assign r_pend_zero = (pend[r_chn] == '0);
  assign r_pend_one  = (pend[r_chn] == {{XFER_BEAT_W{1'b0}}, 1'b1});

  assign m_arid_o     = MST_ID_W'(chn_q);
  assign m_araddr_o   = addr_q;
  assign m_arlen_o    = arlen_q;
  assign m_arburst_o  = AXI_BURST_INCR;

  assign m_rready_o     = atx_rdata_rdy;
  assign atx_rdata_vld  = m_rvalid_i;
  assign atx_rdata      = m_rdata_i;
  assign atx_rdata_chn  = r_chn;
  assign atx_rdata_last = r_pend_one;

  always_comb begin
    ostd_nxt = ostd_cnt;
    if (ar_hs && !r_dec)      ostd_nxt = ostd_cnt + 1'b1;
    else if (!ar_hs && r_dec) ostd_nxt = ostd_cnt - 1'b1;
  end
  assign ostd_lt = (ostd_nxt < OSTD_W'(ATX_NUM_OSTD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      xfer_rdy    <= 1'b0;
      m_arvalid_o <= 1'b0;
      chn_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      arlen_q     <= '0;
      ostd_cnt    <= '0;
    end else begin
      ostd_cnt <= ostd_nxt;
      case (state)
        S_IDLE: begin
          xfer_rdy <= 1'b1;
          if (accept) begin
            chn_q    <= xfer_chn_id;
            addr_q   <= xfer_addr & ~SRC_ADDR_W'(BPB - 1);
            rem_q    <= xfer_beats;
            xfer_rdy <= 1'b0;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          arlen_q     <= ATX_LEN_W'(calc_len - 1'b1);
          m_arvalid_o <= ostd_lt;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (ar_hs) begin
            addr_q      <= next_addr;
            rem_q       <= next_rem;
            m_arvalid_o <= 1'b0;
            if (next_rem != '0) state <= S_CALC;
            else begin
              state    <= S_IDLE;
              xfer_rdy <= 1'b1;
            end
          end else begin
            // once raised, arvalid must hold until the handshake
            m_arvalid_o <= m_arvalid_o | ostd_lt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      xfer_done <= '0;
      xfer_err  <= '0;
    end else begin
      xfer_done <= '0;
      if (accept) xfer_err[xfer_chn_id] <= 1'b0;
      if (r_hs) begin
        if (r_pend_zero) xfer_err[r_chn] <= 1'b1;
        else begin
          pend[r_chn] <= pend[r_chn] - 1'b1;
          if (r_pend_one) xfer_done[r_chn] <= 1'b1;
        end
        if (m_rresp_i[RRESP_ERR_BIT]) xfer_err[r_chn] <= 1'b1;
      end
      if (accept) pend[xfer_chn_id] <= {1'b0, xfer_beats};
    end
  end

`ifdef ADMA_RD_SPLITTER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ar_cnt   <= '0;
      perf_beat_cnt <= '0;
    end else begin
      if (ar_hs) perf_ar_cnt   <= perf_ar_cnt + 1'b1;
      if (r_hs)  perf_beat_cnt <= perf_beat_cnt + 1'b1;
    end
  end
`else
  assign perf_ar_cnt   = '0;
  assign perf_beat_cnt = '0;
`endif
endmodule
